// File: rtl/mem_line_pkg.sv
// Shared definitions for the line-burst memory master: FSM encoding and
// the default line length.
package mem_line_pkg;

    localparam int DEF_BURST_LEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RLAST = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_line_master.sv
// Line-burst master: turns one line request into BURST_LEN word accesses on a
// single-port synchronous RAM and returns the assembled line on read.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request; RAM port parked at addr 0, no write
// WRITE | one RAM write per cycle, beat k of the latched line
// READ  | one RAM read address per cycle; data of beat k-1 captured
// RLAST | last read word arrives from the RAM and is captured
// DONE  | response valid; line held until the requester takes it
module mem_line_master
    import mem_line_pkg::*;
#(
    parameter int AWIDTH    = 3,
    parameter int DWIDTH    = 32,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [AWIDTH-1:0]             req_addr,
    input  logic [BURST_LEN*DWIDTH-1:0]   req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [BURST_LEN*DWIDTH-1:0]   rsp_rdata,
    output logic [AWIDTH-1:0]             mem_addr,
    output logic [DWIDTH-1:0]             mem_din,
    output logic                          mem_we,
    input  logic [DWIDTH-1:0]             mem_dout
);

    localparam int KW = $clog2(BURST_LEN);
    localparam logic [AWIDTH-1:0] LINE_MASK = AWIDTH'(BURST_LEN - 1);
    localparam logic [KW-1:0]     K_LAST    = KW'(BURST_LEN - 1);

    state_t                        state_q, state_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [AWIDTH-1:0]             base_q, base_d;
    logic [BURST_LEN*DWIDTH-1:0]   wdata_q, wdata_d;
    logic [BURST_LEN*DWIDTH-1:0]   rdata_q, rdata_d;

    // Next-state, beat counter and line capture. The direction of the burst
    // is carried by the state itself, so req_write needs no separate flop.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr & ~LINE_MASK;
                    wdata_d = req_wdata;
                    k_d     = '0;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                k_d = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                k_d = k_q + KW'(1);
                // RAM data lags its address by one cycle
                if (k_q != '0) begin
                    rdata_d[(int'(k_q) - 1) * DWIDTH +: DWIDTH] = mem_dout;
                end
                if (k_q == K_LAST) begin
                    state_d = ST_RLAST;
                end
            end
            ST_RLAST: begin
                rdata_d[(BURST_LEN - 1) * DWIDTH +: DWIDTH] = mem_dout;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset parks the block in IDLE at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Output decode from registers only. The beat index replaces the low
    // address bits rather than being added, so a line never carries out.
    always_comb begin
        logic [AWIDTH-1:0] beat_addr;
        logic [AWIDTH-1:0] last_addr;
        beat_addr            = base_q;
        beat_addr[KW-1:0]    = k_q;
        last_addr            = base_q;
        last_addr[KW-1:0]    = K_LAST;
        req_ready            = 1'b0;
        rsp_valid            = 1'b0;
        mem_we               = 1'b0;
        mem_addr             = '0;
        mem_din              = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_WRITE: begin
                mem_we   = 1'b1;
                mem_addr = beat_addr;
                mem_din  = wdata_q[int'(k_q) * DWIDTH +: DWIDTH];
            end
            ST_READ: begin
                mem_addr = beat_addr;
            end
            ST_RLAST: begin
                mem_addr = last_addr;
            end
            ST_DONE: begin
                mem_addr  = last_addr;
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench for mem_line_master with AWIDTH=3, DWIDTH=32, BURST_LEN=2
// and a one-cycle synchronous-read RAM model.
module tb_mem_line_master;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic [2:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    logic [31:0] ram [8];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [63:0] wdata;
        logic [2:0]  a0;
        logic [2:0]  a1;
        logic [63:0] rdata;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs [7];

    mem_line_master #(
        .AWIDTH    (3),
        .DWIDTH    (32),
        .BURST_LEN (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM model: synchronous write, one-cycle read latency
    initial begin
        for (int i = 0; i < 8; i++) ram[i] = 32'hF000_0000 + i;
    end
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int   cyc;
        logic got;
        chk($sformatf("v%0d ready_idle", idx), 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        req_wdata = '0;
        cyc = 1;
        got = 1'b0;
        while (cyc <= 10 && !got) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                chk($sformatf("v%0d c%0d ready_busy", idx, cyc), 64'(req_ready), 64'd0);
                if (cyc == 1) begin
                    chk($sformatf("v%0d c1 we", idx), 64'(mem_we), 64'(v.wr));
                    chk($sformatf("v%0d c1 addr", idx), 64'(mem_addr), 64'(v.a0));
                    if (v.wr) chk($sformatf("v%0d c1 din", idx), 64'(mem_din), 64'(v.wdata[31:0]));
                end else if (cyc == 2) begin
                    chk($sformatf("v%0d c2 we", idx), 64'(mem_we), 64'(v.wr));
                    chk($sformatf("v%0d c2 addr", idx), 64'(mem_addr), 64'(v.a1));
                    if (v.wr) chk($sformatf("v%0d c2 din", idx), 64'(mem_din), 64'(v.wdata[63:32]));
                end else begin
                    chk($sformatf("v%0d c%0d we", idx, cyc), 64'(mem_we), 64'd0);
                    chk($sformatf("v%0d c%0d addr", idx, cyc), 64'(mem_addr), 64'(v.a1));
                end
                tick();
                cyc++;
            end
        end
        chk($sformatf("v%0d latency", idx), got ? 64'(cyc) : 64'd0, 64'(v.lat));
        chk($sformatf("v%0d rdata", idx), rsp_rdata, v.rdata);
        chk($sformatf("v%0d done addr", idx), 64'(mem_addr), 64'(v.a1));
        chk($sformatf("v%0d done we", idx), 64'(mem_we), 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            tick();
            chk($sformatf("v%0d hold%0d valid", idx, h), 64'(rsp_valid), 64'd1);
            chk($sformatf("v%0d hold%0d rdata", idx, h), rsp_rdata, v.rdata);
            chk($sformatf("v%0d hold%0d ready", idx, h), 64'(req_ready), 64'd0);
            chk($sformatf("v%0d hold%0d we", idx, h), 64'(mem_we), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d idle valid", idx), 64'(rsp_valid), 64'd0);
        chk($sformatf("v%0d idle ready", idx), 64'(req_ready), 64'd1);
        chk($sformatf("v%0d idle we", idx), 64'(mem_we), 64'd0);
        chk($sformatf("v%0d idle addr", idx), 64'(mem_addr), 64'd0);
        chk($sformatf("v%0d idle din", idx), 64'(mem_din), 64'd0);
    endtask

    initial begin
        int   cyc;
        vec_t v;

        //          wr    addr  wdata                      a0    a1    rdata                      lat hold
        vecs[0] = '{1'b1, 3'd4, {32'hB, 32'hA},            3'd4, 3'd5, 64'd0,                     3,  0};
        vecs[1] = '{1'b0, 3'd5, 64'd0,                     3'd4, 3'd5, {32'hB, 32'hA},            4,  0};
        vecs[2] = '{1'b1, 3'd7, {32'h77, 32'h66},          3'd6, 3'd7, {32'hB, 32'hA},            3,  0};
        vecs[3] = '{1'b0, 3'd7, 64'd0,                     3'd6, 3'd7, {32'h77, 32'h66},          4,  5};
        vecs[4] = '{1'b1, 3'd0, {32'hD1, 32'hD0},          3'd0, 3'd1, {32'h77, 32'h66},          3,  0};
        vecs[5] = '{1'b0, 3'd1, 64'd0,                     3'd0, 3'd1, {32'hD1, 32'hD0},          4,  0};
        vecs[6] = '{1'b0, 3'd4, 64'd0,                     3'd4, 3'd5, {32'hB, 32'hA},            4,  2};

        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset we", 64'(mem_we), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rdata", rsp_rdata, 64'd0);
        chk("reset ready", 64'(req_ready), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;
        chk("post reset ready", 64'(req_ready), 64'd1);
        chk("post reset addr", 64'(mem_addr), 64'd0);

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // reset in the middle of a write burst
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 3'd4;
        req_wdata = {32'h55, 32'h44};
        tick();
        req_valid = 1'b0;
        chk("abort c1 we", 64'(mem_we), 64'd1);
        chk("abort c1 addr", 64'(mem_addr), 64'd4);
        tick();
        chk("abort c2 addr", 64'(mem_addr), 64'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("abort we", 64'(mem_we), 64'd0);
        chk("abort ready", 64'(req_ready), 64'd1);
        chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort rdata", rsp_rdata, 64'd0);
        tick();
        tick();
        chk("abort ram4", 64'(ram[4]), 64'h44);
        chk("abort ram5", 64'(ram[5]), 64'hB);
        reset_n = 1'b1;
        chk("abort release ready", 64'(req_ready), 64'd1);
        v = '{1'b0, 3'd4, 64'd0, 3'd4, 3'd5, {32'hB, 32'h44}, 4, 0};
        run_txn(7, v);

        // back-to-back with req_valid held high across the write
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 3'd2;
        req_wdata = {32'h22, 32'h21};
        rsp_ready = 1'b1;
        chk("b2b ready0", 64'(req_ready), 64'd1);
        tick();
        req_write = 1'b0;
        req_wdata = '0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("b2b c%0d ready", c), 64'(req_ready), 64'd0);
            chk($sformatf("b2b c%0d rsp_valid", c), 64'(rsp_valid), 64'(c == 3));
            tick();
        end
        chk("b2b c4 ready", 64'(req_ready), 64'd1);
        chk("b2b c4 rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        chk("b2b c5 ready", 64'(req_ready), 64'd0);
        chk("b2b c5 we", 64'(mem_we), 64'd0);
        chk("b2b c5 addr", 64'(mem_addr), 64'd2);
        cyc = 5;
        while (!rsp_valid && cyc < 12) begin
            tick();
            cyc++;
        end
        chk("b2b read latency", 64'(cyc), 64'd8);
        chk("b2b rdata", rsp_rdata, {32'h22, 32'h21});
        tick();
        rsp_ready = 1'b0;
        chk("b2b end ready", 64'(req_ready), 64'd1);
        chk("b2b end valid", 64'(rsp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
